// File: rtl/mips_pipe_pkg.sv
// Shared encodings for the MIPS 5-stage pipeline control slice.
// Contents: forwarding-select codes, branch-stage identifiers, counter widths,
// hazard FSM state enum and the packed per-stage control bundle.
package mips_pipe_pkg;

    // EX operand source selects
    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

    // Stage in which taken branches are resolved
    localparam int unsigned BR_EX  = 1;
    localparam int unsigned BR_MEM = 2;

    // Counter widths: load-use stall (1..7), dmem wait (1..255), perf counters
    localparam int unsigned LD_CW  = 3;
    localparam int unsigned WT_CW  = 8;
    localparam int unsigned PERF_W = 32;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LDSTALL = 2'd1,
        MEMWAIT = 2'd2
    } haz_state_e;

    // Per-stage enables and squash controls driven into the pipeline registers
    typedef struct packed {
        logic pc_we;
        logic ifid_we;
        logic idex_we;
        logic exmem_we;
        logic memwb_we;
        logic ifid_flush;
        logic idex_bubble;
        logic exmem_flush;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t CTRL_RUN    = '{pc_we: 1'b1, ifid_we: 1'b1, idex_we: 1'b1,
                                           exmem_we: 1'b1, memwb_we: 1'b1, ifid_flush: 1'b0,
                                           idex_bubble: 1'b0, exmem_flush: 1'b0};
    localparam pipe_ctrl_t CTRL_FREEZE = '{default: 1'b0};

endpackage

// File: rtl/mips_fwd_unit.sv
// Forwarding compare for one EX operand.
// Ports: src_i (EX source reg), mem_dest_i/mem_regwrite_i (EXE2MEM producer),
//        wb_dest_i/wb_regwrite_i (MEM2WB producer), sel_o (operand select).
// The younger producer in MEM wins over WB; r0 never forwards.
module mips_fwd_unit
    import mips_pipe_pkg::*;
#(
    parameter int unsigned REG_AW = 5
) (
    input  logic [REG_AW-1:0] src_i,
    input  logic [REG_AW-1:0] mem_dest_i,
    input  logic              mem_regwrite_i,
    input  logic [REG_AW-1:0] wb_dest_i,
    input  logic              wb_regwrite_i,
    output logic [1:0]        sel_o
);

    always_comb begin
        sel_o = FWD_REG;
        if (mem_regwrite_i && (mem_dest_i != '0) && (mem_dest_i == src_i)) begin
            sel_o = FWD_EXMEM;
        end else if (wb_regwrite_i && (wb_dest_i != '0) && (wb_dest_i == src_i)) begin
            sel_o = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/mips_hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage MIPS core.
// Produces EX forwarding selects, load-use stalls, taken-branch flushes and
// data-memory wait freezes, and drives the stage-register enables/squashes.
// Ports:
//   clock, reset (sync, active-low)
//   id_*  : ID-stage source regs and use flags      ex_* : EX-stage regs, load flag
//   mem_* : MEM-stage dest/write/request            wb_* : WB-stage dest/write
//   branch_taken, dmem_ack                          fwd_a/fwd_b : EX operand selects
//   pc_we, ifid_we, idex_we, exmem_we, memwb_we     : stage load enables
//   ifid_flush, idex_bubble, exmem_flush            : squash controls
//   mem_err : sticky dmem timeout flag
// Optional build macro HAZ_PERF_CNT_EN adds saturating 32-bit stall_cnt,
// flush_cnt and memwait_cnt outputs.
// Priority per cycle: dmem freeze > branch flush > load-use stall.
module mips_hazard_ctrl
    import mips_pipe_pkg::*;
#(
    parameter int unsigned REG_AW       = 5,
    parameter int unsigned LOAD_USE_CYC = 1,
    parameter int unsigned BRANCH_STAGE = 2,
    parameter int unsigned MEM_TIMEOUT  = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic [REG_AW-1:0] ex_rs,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic [REG_AW-1:0] ex_dest,
    input  logic              ex_regwrite,
    input  logic              ex_memread,
    input  logic [REG_AW-1:0] mem_dest,
    input  logic              mem_regwrite,
    input  logic              mem_req,
    input  logic [REG_AW-1:0] wb_dest,
    input  logic              wb_regwrite,
    input  logic              branch_taken,
    input  logic              dmem_ack,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              pc_we,
    output logic              ifid_we,
    output logic              idex_we,
    output logic              exmem_we,
    output logic              memwb_we,
    output logic              ifid_flush,
    output logic              idex_bubble,
    output logic              exmem_flush,
    output logic              mem_err
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [PERF_W-1:0] stall_cnt,
    output logic [PERF_W-1:0] flush_cnt,
    output logic [PERF_W-1:0] memwait_cnt
`endif
);

    haz_state_e       state_q, state_d;
    logic [LD_CW-1:0] ld_cnt_q, ld_cnt_d;
    logic [WT_CW-1:0] wait_cnt_q, wait_cnt_d;
    logic [WT_CW-1:0] wait_inc;
    logic             mem_err_q, mem_err_d;
    logic             load_use;
    logic             release_c;
    logic             freeze;
    pipe_ctrl_t       ctrl_c;

    // A load-use hazard is keyed on ex_memread alone; the EX write flag is not needed.
    logic unused_ex_regwrite;
    assign unused_ex_regwrite = ex_regwrite;

    // Operand forwarding, one compare per EX source
    mips_fwd_unit #(.REG_AW(REG_AW)) u_fwd_a (
        .src_i          (ex_rs),
        .mem_dest_i     (mem_dest),
        .mem_regwrite_i (mem_regwrite),
        .wb_dest_i      (wb_dest),
        .wb_regwrite_i  (wb_regwrite),
        .sel_o          (fwd_a)
    );

    mips_fwd_unit #(.REG_AW(REG_AW)) u_fwd_b (
        .src_i          (ex_rt),
        .mem_dest_i     (mem_dest),
        .mem_regwrite_i (mem_regwrite),
        .wb_dest_i      (wb_dest),
        .wb_regwrite_i  (wb_regwrite),
        .sel_o          (fwd_b)
    );

    assign load_use = ex_memread && (ex_dest != '0) &&
                      ((id_use_rs && (ex_dest == id_rs)) || (id_use_rt && (ex_dest == id_rt)));

    assign wait_inc = wait_cnt_q + WT_CW'(1);

    // State, counters and sticky error flag
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= RUN;
            ld_cnt_q   <= '0;
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ld_cnt_q   <= ld_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
        end
    end

    // Next state and per-stage controls
    always_comb begin
        state_d    = RUN;
        ld_cnt_d   = '0;
        wait_cnt_d = '0;
        mem_err_d  = mem_err_q;
        ctrl_c     = CTRL_RUN;
        // A wait ends on ack or when the frozen-cycle count reaches the timeout
        release_c  = (state_q == MEMWAIT) && (dmem_ack || (wait_cnt_q == WT_CW'(MEM_TIMEOUT)));
        freeze     = (state_q == MEMWAIT) ? !release_c : (mem_req && !dmem_ack);

        if (freeze) begin
            // Whole pipe holds; any pending load-use stall is dropped and re-detected later
            state_d    = MEMWAIT;
            wait_cnt_d = wait_inc;
            ctrl_c     = CTRL_FREEZE;
            if (wait_inc == WT_CW'(MEM_TIMEOUT)) begin
                mem_err_d = 1'b1;
            end
        end else if (branch_taken) begin
            ctrl_c.ifid_flush  = 1'b1;
            ctrl_c.idex_bubble = 1'b1;
            ctrl_c.exmem_flush = (BRANCH_STAGE == BR_MEM);
        end else if ((state_q == LDSTALL) || load_use) begin
            ctrl_c.pc_we       = 1'b0;
            ctrl_c.ifid_we     = 1'b0;
            ctrl_c.idex_bubble = 1'b1;
            if (state_q == LDSTALL) begin
                ld_cnt_d = ld_cnt_q - LD_CW'(1);
                state_d  = (ld_cnt_q == LD_CW'(1)) ? RUN : LDSTALL;
            end else if (LOAD_USE_CYC > 1) begin
                // First stall cycle happens here; the counter holds the rest
                state_d  = LDSTALL;
                ld_cnt_d = LD_CW'(LOAD_USE_CYC - 1);
            end
        end
    end

    assign pc_we       = ctrl_c.pc_we;
    assign ifid_we     = ctrl_c.ifid_we;
    assign idex_we     = ctrl_c.idex_we;
    assign exmem_we    = ctrl_c.exmem_we;
    assign memwb_we    = ctrl_c.memwb_we;
    assign ifid_flush  = ctrl_c.ifid_flush;
    assign idex_bubble = ctrl_c.idex_bubble;
    assign exmem_flush = ctrl_c.exmem_flush;
    assign mem_err     = mem_err_q;

`ifdef HAZ_PERF_CNT_EN
    logic [PERF_W-1:0] stall_cnt_q, flush_cnt_q, memwait_cnt_q;

    // Saturating event counters; stall = PC held while the back end still advances
    always_ff @(posedge clock) begin
        if (!reset) begin
            stall_cnt_q   <= '0;
            flush_cnt_q   <= '0;
            memwait_cnt_q <= '0;
        end else begin
            if (!ctrl_c.pc_we && ctrl_c.memwb_we && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + PERF_W'(1);
            end
            if (ctrl_c.ifid_flush && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + PERF_W'(1);
            end
            if (!ctrl_c.memwb_we && (memwait_cnt_q != '1)) begin
                memwait_cnt_q <= memwait_cnt_q + PERF_W'(1);
            end
        end
    end

    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;
    assign memwait_cnt = memwait_cnt_q;
`endif

endmodule

// File: tb/tb_mips_hazard_ctrl.sv
// Self-checking bench for mips_hazard_ctrl (LOAD_USE_CYC=2, BRANCH_STAGE=2, MEM_TIMEOUT=15).
module tb_mips_hazard_ctrl;

    localparam int unsigned AW  = 5;
    localparam int unsigned LUC = 2;
    localparam int unsigned BST = 2;
    localparam int unsigned MTO = 15;

    // {pc_we, ifid_we, idex_we, exmem_we, memwb_we, ifid_flush, idex_bubble, exmem_flush}
    localparam logic [7:0] C_RUN    = 8'b11111_000;
    localparam logic [7:0] C_STALL  = 8'b00111_010;
    localparam logic [7:0] C_FREEZE = 8'b00000_000;
    localparam logic [7:0] C_BR     = 8'b11111_111;

    logic          clock = 1'b0;
    logic          reset;
    logic [AW-1:0] id_rs, id_rt, ex_rs, ex_rt, ex_dest, mem_dest, wb_dest;
    logic          id_use_rs, id_use_rt, ex_regwrite, ex_memread;
    logic          mem_regwrite, mem_req, wb_regwrite, branch_taken, dmem_ack;
    logic [1:0]    fwd_a, fwd_b;
    logic          pc_we, ifid_we, idex_we, exmem_we, memwb_we;
    logic          ifid_flush, idex_bubble, exmem_flush, mem_err;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0]   stall_cnt, flush_cnt, memwait_cnt;
`endif

    int vectors     = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    mips_hazard_ctrl #(
        .REG_AW(AW), .LOAD_USE_CYC(LUC), .BRANCH_STAGE(BST), .MEM_TIMEOUT(MTO)
    ) dut (
        .clock(clock), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dest(ex_dest),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .mem_dest(mem_dest), .mem_regwrite(mem_regwrite), .mem_req(mem_req),
        .wb_dest(wb_dest), .wb_regwrite(wb_regwrite),
        .branch_taken(branch_taken), .dmem_ack(dmem_ack),
        .fwd_a(fwd_a), .fwd_b(fwd_b),
        .pc_we(pc_we), .ifid_we(ifid_we), .idex_we(idex_we),
        .exmem_we(exmem_we), .memwb_we(memwb_we),
        .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .exmem_flush(exmem_flush),
        .mem_err(mem_err)
`ifdef HAZ_PERF_CNT_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .memwait_cnt(memwait_cnt)
`endif
    );

    typedef struct {
        string         name;
        logic [AW-1:0] ex_rs, ex_rt, mem_dest;
        logic          mem_rw;
        logic [AW-1:0] wb_dest;
        logic          wb_rw;
        logic [AW-1:0] id_rs, id_rt;
        logic          use_rs, use_rt;
        logic [AW-1:0] ex_dest;
        logic          ex_mr, req, ack, br;
        logic [1:0]    fa, fb;
        logic [7:0]    ctl;
    } vec_t;

    vec_t tbl[16];

    function automatic logic [12:0] obs();
        return {fwd_a, fwd_b, pc_we, ifid_we, idex_we, exmem_we, memwb_we,
                ifid_flush, idex_bubble, exmem_flush, mem_err};
    endfunction

    function automatic logic [12:0] expv(logic [1:0] fa, logic [1:0] fb, logic [7:0] ctl, logic err);
        return {fa, fb, ctl, err};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        id_rs = '0; id_rt = '0; id_use_rs = 1'b0; id_use_rt = 1'b0;
        ex_rs = '0; ex_rt = '0; ex_dest = '0; ex_regwrite = 1'b0; ex_memread = 1'b0;
        mem_dest = '0; mem_regwrite = 1'b0; mem_req = 1'b0;
        wb_dest = '0; wb_regwrite = 1'b0; branch_taken = 1'b0; dmem_ack = 1'b0;
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are sampled at the falling edge
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic rst_pulse();
        idle();
        reset = 1'b0;
        step();
        reset = 1'b1;
    endtask

    task automatic load_use_inputs();
        ex_memread = 1'b1; ex_dest = 5'd5; id_rs = 5'd5; id_use_rs = 1'b1;
    endtask

    // Forwarding select from the stage destinations, newest producer first
    function automatic logic [1:0] ref_fwd(logic [AW-1:0] src);
        if (mem_regwrite && mem_dest != 0 && mem_dest == src) return 2'b10;
        if (wb_regwrite && wb_dest != 0 && wb_dest == src) return 2'b01;
        return 2'b00;
    endfunction

    initial begin
        int n;
        // reference-model bookkeeping for the random phase
        int  stall_left;
        int  waited;
        bit  waiting;
        bit  err;
        bit  m_freeze, m_branch, m_stall, m_lu;
        logic [7:0] m_ctl;

        tbl[0]  = '{"fwd_mem",     3,4,3,1, 0,0, 0,0,0,0, 0,0,0,0,0, 2'b10,2'b00, C_RUN};
        tbl[1]  = '{"fwd_mem_wb",  3,4,3,1, 3,1, 0,0,0,0, 0,0,0,0,0, 2'b10,2'b00, C_RUN};
        tbl[2]  = '{"fwd_r0",      0,0,0,1, 0,1, 0,0,0,0, 0,0,0,0,0, 2'b00,2'b00, C_RUN};
        tbl[3]  = '{"fwd_wb_b",    1,7,7,0, 7,1, 0,0,0,0, 0,0,0,0,0, 2'b00,2'b01, C_RUN};
        tbl[4]  = '{"fwd_both",    5,5,5,1, 2,1, 0,0,0,0, 0,0,0,0,0, 2'b10,2'b10, C_RUN};
        tbl[5]  = '{"fwd_split",   2,6,6,1, 2,1, 0,0,0,0, 0,0,0,0,0, 2'b01,2'b10, C_RUN};
        tbl[6]  = '{"ldu_rs",      0,0,0,0, 0,0, 5,0,1,0, 5,1,0,0,0, 2'b00,2'b00, C_STALL};
        tbl[7]  = '{"ldu_nouse",   0,0,0,0, 0,0, 5,0,0,0, 5,1,0,0,0, 2'b00,2'b00, C_RUN};
        tbl[8]  = '{"ldu_r0",      0,0,0,0, 0,0, 0,0,1,0, 0,1,0,0,0, 2'b00,2'b00, C_RUN};
        tbl[9]  = '{"ldu_rt",      0,0,0,0, 0,0, 0,5,0,1, 5,1,0,0,0, 2'b00,2'b00, C_STALL};
        tbl[10] = '{"ldu_noload",  0,0,0,0, 0,0, 5,0,1,0, 5,0,0,0,0, 2'b00,2'b00, C_RUN};
        tbl[11] = '{"branch",      0,0,0,0, 0,0, 0,0,0,0, 0,0,0,0,1, 2'b00,2'b00, C_BR};
        tbl[12] = '{"br_ldu",      0,0,0,0, 0,0, 5,0,1,0, 5,1,0,0,1, 2'b00,2'b00, C_BR};
        tbl[13] = '{"memwait",     0,0,0,0, 0,0, 0,0,0,0, 0,0,1,0,0, 2'b00,2'b00, C_FREEZE};
        tbl[14] = '{"mem_ack",     0,0,0,0, 0,0, 0,0,0,0, 0,0,1,1,0, 2'b00,2'b00, C_RUN};
        tbl[15] = '{"mem_over_br", 3,0,3,1, 0,0, 5,0,1,0, 5,1,1,0,1, 2'b10,2'b00, C_FREEZE};

        idle();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        @(negedge clock);
        check("reset_state", 32'(obs()), 32'(expv(2'b00, 2'b00, C_RUN, 1'b0)));
        step();

        // Single-cycle table, each vector starting from a freshly reset RUN state
        foreach (tbl[i]) begin
            rst_pulse();
            ex_rs = tbl[i].ex_rs; ex_rt = tbl[i].ex_rt;
            mem_dest = tbl[i].mem_dest; mem_regwrite = tbl[i].mem_rw;
            wb_dest = tbl[i].wb_dest; wb_regwrite = tbl[i].wb_rw;
            id_rs = tbl[i].id_rs; id_rt = tbl[i].id_rt;
            id_use_rs = tbl[i].use_rs; id_use_rt = tbl[i].use_rt;
            ex_dest = tbl[i].ex_dest; ex_memread = tbl[i].ex_mr; ex_regwrite = tbl[i].ex_mr;
            mem_req = tbl[i].req; dmem_ack = tbl[i].ack; branch_taken = tbl[i].br;
            @(negedge clock);
            check(tbl[i].name, 32'(obs()), 32'(expv(tbl[i].fa, tbl[i].fb, tbl[i].ctl, 1'b0)));
            step();
        end

        // Load-use with two stall cycles; EX turns into a bubble after the first
        rst_pulse();
        load_use_inputs();
        @(negedge clock); check("ldu_c0", 32'(obs()), 32'(expv(0, 0, C_STALL, 0)));
        step();
        ex_memread = 1'b0; ex_dest = '0;
        @(negedge clock); check("ldu_c1", 32'(obs()), 32'(expv(0, 0, C_STALL, 0)));
        step();
        @(negedge clock); check("ldu_c2", 32'(obs()), 32'(expv(0, 0, C_RUN, 0)));
        step();

        // Taken branch flushes for exactly one cycle
        rst_pulse();
        branch_taken = 1'b1;
        @(negedge clock); check("br_c0", 32'(obs()), 32'(expv(0, 0, C_BR, 0)));
        step();
        branch_taken = 1'b0;
        @(negedge clock); check("br_c1", 32'(obs()), 32'(expv(0, 0, C_RUN, 0)));
        step();

        // Three-cycle memory wait, released by ack
        rst_pulse();
        mem_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock); check($sformatf("mw_c%0d", k), 32'(obs()), 32'(expv(0, 0, C_FREEZE, 0)));
            step();
        end
        dmem_ack = 1'b1;
        @(negedge clock); check("mw_ack", 32'(obs()), 32'(expv(0, 0, C_RUN, 0)));
        step();
        idle();
        @(negedge clock); check("mw_after", 32'(obs()), 32'(expv(0, 0, C_RUN, 0)));
        step();

        // Memory never acks: forced release after MTO frozen cycles, sticky error
        rst_pulse();
        mem_req = 1'b1;
        n = 0;
        @(negedge clock);
        while (!memwb_we && n < 40) begin
            n++;
            step();
            @(negedge clock);
        end
        check("to_len", 32'(n), 32'(MTO));
        check("to_release", 32'(obs()), 32'(expv(0, 0, C_RUN, 1)));
        step();
        mem_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock); check($sformatf("to_sticky%0d", k), 32'(obs()), 32'(expv(0, 0, C_RUN, 1)));
            step();
        end
        rst_pulse();
        @(negedge clock); check("to_clear", 32'(obs()), 32'(expv(0, 0, C_RUN, 0)));
        step();

        // Reset taken in the middle of a multi-cycle stall
        rst_pulse();
        load_use_inputs();
        @(negedge clock); check("rstld_c0", 32'(obs()), 32'(expv(0, 0, C_STALL, 0)));
        step();
        idle();
        reset = 1'b0;
        step();
        reset = 1'b1;
        @(negedge clock); check("rstld_run", 32'(obs()), 32'(expv(0, 0, C_RUN, 0)));
        step();

        // Load-use and branch together: flush only, no stall afterwards
        rst_pulse();
        load_use_inputs();
        branch_taken = 1'b1;
        @(negedge clock); check("ldubr_c0", 32'(obs()), 32'(expv(0, 0, C_BR, 0)));
        step();
        idle();
        @(negedge clock); check("ldubr_c1", 32'(obs()), 32'(expv(0, 0, C_RUN, 0)));
        step();

        // Random traffic against the reference model
        rst_pulse();
        stall_left = 0; waited = 0; waiting = 0; err = 0;
        for (int c = 0; c < 3000; c++) begin
            reset        = ($urandom_range(0, 63) != 0);
            id_rs        = AW'($urandom_range(0, 3));
            id_rt        = AW'($urandom_range(0, 3));
            id_use_rs    = 1'($urandom_range(0, 1));
            id_use_rt    = 1'($urandom_range(0, 1));
            ex_rs        = AW'($urandom_range(0, 3));
            ex_rt        = AW'($urandom_range(0, 3));
            ex_dest      = AW'($urandom_range(0, 3));
            ex_memread   = ($urandom_range(0, 9) < 3);
            ex_regwrite  = 1'($urandom_range(0, 1));
            mem_dest     = AW'($urandom_range(0, 3));
            mem_regwrite = 1'($urandom_range(0, 1));
            mem_req      = ($urandom_range(0, 3) == 0) || (waiting && $urandom_range(0, 3) != 0);
            dmem_ack     = ($urandom_range(0, 9) < 4);
            wb_dest      = AW'($urandom_range(0, 3));
            wb_regwrite  = 1'($urandom_range(0, 1));
            branch_taken = ($urandom_range(0, 9) == 0);

            m_lu = ex_memread && ex_dest != 0 &&
                   ((id_use_rs && ex_dest == id_rs) || (id_use_rt && ex_dest == id_rt));
            if (waiting) m_freeze = !(dmem_ack || waited == int'(MTO));
            else         m_freeze = mem_req && !dmem_ack;
            m_branch = !m_freeze && branch_taken;
            m_stall  = !m_freeze && !m_branch && (stall_left > 0 || m_lu);
            if (m_freeze)      m_ctl = C_FREEZE;
            else if (m_branch) m_ctl = (BST == 2) ? C_BR : 8'b11111_110;
            else if (m_stall)  m_ctl = C_STALL;
            else               m_ctl = C_RUN;

            @(negedge clock);
            check($sformatf("rand%0d", c), 32'(obs()),
                  32'(expv(ref_fwd(ex_rs), ref_fwd(ex_rt), m_ctl, err)));

            if (!reset) begin
                stall_left = 0; waited = 0; waiting = 0; err = 0;
            end else if (m_freeze) begin
                waited     = waiting ? waited + 1 : 1;
                waiting    = 1;
                stall_left = 0;
                if (waited == int'(MTO)) err = 1;
            end else begin
                waiting = 0;
                waited  = 0;
                if (m_stall) stall_left = (stall_left > 0) ? stall_left - 1 : int'(LUC) - 1;
                else         stall_left = 0;
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
